// File: rtl/regex_job_driver.sv
// Hardware initiator for the coprocessor command/status registers: loads a word
// stream, starts a regex run, polls for completion, reads the cycle count, restores IDLE.
`timescale 1ns/1ps
module regex_job_driver #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [ADDR_WIDTH-1:0] job_base_addr,
  input  logic [ADDR_WIDTH-1:0] job_word_count,
  input  logic [ADDR_WIDTH-1:0] job_start_cc_pointer,
  input  logic [REG_WIDTH-1:0]  timeout_limit,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic [REG_WIDTH-1:0]  word_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [1:0]            res_code,
  output logic [REG_WIDTH-1:0]  res_elapsed,
  output logic                  busy,
  output logic [REG_WIDTH-1:0]  data_in_register,
  output logic [REG_WIDTH-1:0]  address_register,
  output logic [REG_WIDTH-1:0]  start_cc_pointer_register,
  output logic [REG_WIDTH-1:0]  cmd_register,
  input  logic [REG_WIDTH-1:0]  status_register,
  input  logic [REG_WIDTH-1:0]  data_o_register
);

  localparam logic [REG_WIDTH-1:0] CMD_NOP                = REG_WIDTH'(0);
  localparam logic [REG_WIDTH-1:0] CMD_WRITE              = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] CMD_START              = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = REG_WIDTH'(3);
  localparam logic [REG_WIDTH-1:0] CMD_RESTART            = REG_WIDTH'(4);
  localparam logic [REG_WIDTH-1:0] CMD_RESET              = REG_WIDTH'(5);

  localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = REG_WIDTH'(0);
  localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = REG_WIDTH'(3);
  localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = REG_WIDTH'(4);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, RUN, READ_CC, RESTART, RESET_CP, REPORT
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] base, base_next;
  logic [ADDR_WIDTH-1:0] count, count_next;
  logic [ADDR_WIDTH-1:0] pointer, pointer_next;
  logic [ADDR_WIDTH-1:0] index, index_next;
  logic [REG_WIDTH-1:0]  counter, counter_next;
  logic [REG_WIDTH-1:0]  cmd_next, data_next, addr_next, ptr_next, elapsed_next;
  logic [1:0]            code_next;

  logic [ADDR_WIDTH-1:0] addr_sum;
  logic [REG_WIDTH-1:0]  counter_inc;
  logic                  timeout_hit;
  logic                  last_word;

  assign addr_sum    = base + index;
  assign last_word   = (index + ADDR_WIDTH'(1)) == count;
  assign counter_inc = (counter == '1) ? counter : counter + REG_WIDTH'(1);
  assign timeout_hit = (timeout_limit != '0) && (counter >= timeout_limit);

  always_comb begin
    state_next   = state;
    base_next    = base;
    count_next   = count;
    pointer_next = pointer;
    index_next   = index;
    counter_next = counter;
    cmd_next     = CMD_NOP;
    data_next    = data_in_register;
    addr_next    = address_register;
    ptr_next     = start_cc_pointer_register;
    code_next    = res_code;
    elapsed_next = res_elapsed;
    job_ready    = 1'b0;
    word_ready   = 1'b0;
    res_valid    = 1'b0;
    busy         = (state != IDLE);

    case (state)
      IDLE: begin
        job_ready = (status_register == STATUS_IDLE);
        if (job_valid && job_ready) begin
          base_next    = job_base_addr;
          count_next   = job_word_count;
          pointer_next = job_start_cc_pointer;
          index_next   = '0;
          if (job_word_count != '0) begin
            state_next = LOAD;
          end else begin
            state_next   = START;
            cmd_next     = CMD_START;
            ptr_next     = REG_WIDTH'(job_start_cc_pointer);
            counter_next = '0;
          end
        end
      end

      LOAD: begin
        word_ready = 1'b1;
        if (word_valid) begin
          cmd_next   = CMD_WRITE;
          data_next  = word_data;
          addr_next  = REG_WIDTH'(addr_sum);
          index_next = index + ADDR_WIDTH'(1);
          if (last_word) begin
            state_next   = START;
            ptr_next     = REG_WIDTH'(pointer);
            counter_next = '0;
          end
        end
      end

      // Timeout wins over any status change seen in the same cycle.
      START: begin
        cmd_next     = CMD_START;
        counter_next = counter_inc;
        if (timeout_hit) begin
          cmd_next     = CMD_RESET;
          code_next    = 2'd3;
          elapsed_next = counter;
          state_next   = RESET_CP;
        end else if (status_register == STATUS_RUNNING) begin
          cmd_next   = CMD_NOP;
          state_next = RUN;
        end
      end

      RUN: begin
        counter_next = counter_inc;
        if (timeout_hit) begin
          cmd_next     = CMD_RESET;
          code_next    = 2'd3;
          elapsed_next = counter;
          state_next   = RESET_CP;
        end else if (status_register == STATUS_ACCEPTED) begin
          cmd_next   = CMD_READ_ELAPSED_CLOCK;
          code_next  = 2'd0;
          state_next = READ_CC;
        end else if (status_register == STATUS_REJECTED) begin
          cmd_next   = CMD_READ_ELAPSED_CLOCK;
          code_next  = 2'd1;
          state_next = READ_CC;
        end else if (status_register == STATUS_ERROR) begin
          cmd_next   = CMD_READ_ELAPSED_CLOCK;
          code_next  = 2'd2;
          state_next = READ_CC;
        end
      end

      READ_CC: begin
        elapsed_next = data_o_register;
        cmd_next     = CMD_RESTART;
        state_next   = RESTART;
      end

      RESTART: begin
        cmd_next = CMD_RESTART;
        if (status_register == STATUS_IDLE) begin
          cmd_next   = CMD_NOP;
          state_next = REPORT;
        end
      end

      RESET_CP: begin
        state_next = REPORT;
      end

      REPORT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                     <= IDLE;
      base                      <= '0;
      count                     <= '0;
      pointer                   <= '0;
      index                     <= '0;
      counter                   <= '0;
      cmd_register              <= CMD_NOP;
      data_in_register          <= '0;
      address_register          <= '0;
      start_cc_pointer_register <= '0;
      res_code                  <= 2'd0;
      res_elapsed               <= '0;
    end else begin
      state                     <= state_next;
      base                      <= base_next;
      count                     <= count_next;
      pointer                   <= pointer_next;
      index                     <= index_next;
      counter                   <= counter_next;
      cmd_register              <= cmd_next;
      data_in_register          <= data_next;
      address_register          <= addr_next;
      start_cc_pointer_register <= ptr_next;
      res_code                  <= code_next;
      res_elapsed               <= elapsed_next;
    end
  end

endmodule

// File: tb/tb_regex_job_driver.sv
// Bench for regex_job_driver: each job is scheduled open-loop and a cycle-timeline
// model predicts every output, which a single negedge process compares.
`timescale 1ns/1ps
module tb_regex_job_driver;

  localparam int RW = 32;
  localparam int AW = 11;

  localparam logic [31:0] CMD_NOP     = 32'd0;
  localparam logic [31:0] CMD_WRITE   = 32'd1;
  localparam logic [31:0] CMD_START   = 32'd2;
  localparam logic [31:0] CMD_READ    = 32'd3;
  localparam logic [31:0] CMD_RESTART = 32'd4;
  localparam logic [31:0] CMD_RESET   = 32'd5;

  localparam logic [31:0] ST_IDLE     = 32'd0;
  localparam logic [31:0] ST_RUNNING  = 32'd1;
  localparam logic [31:0] ST_ACCEPTED = 32'd2;
  localparam logic [31:0] ST_REJECTED = 32'd3;
  localparam logic [31:0] ST_ERROR    = 32'd4;

  logic          clk = 1'b0;
  logic          reset;
  logic          job_valid;
  logic          job_ready;
  logic [AW-1:0] job_base_addr;
  logic [AW-1:0] job_word_count;
  logic [AW-1:0] job_start_cc_pointer;
  logic [RW-1:0] timeout_limit;
  logic          word_valid;
  logic          word_ready;
  logic [RW-1:0] word_data;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_code;
  logic [RW-1:0] res_elapsed;
  logic          busy;
  logic [RW-1:0] data_in_register, address_register, start_cc_pointer_register, cmd_register;
  logic [RW-1:0] status_register, data_o_register;

  regex_job_driver #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_base_addr(job_base_addr), .job_word_count(job_word_count),
    .job_start_cc_pointer(job_start_cc_pointer), .timeout_limit(timeout_limit),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_code(res_code),
    .res_elapsed(res_elapsed), .busy(busy),
    .data_in_register(data_in_register), .address_register(address_register),
    .start_cc_pointer_register(start_cc_pointer_register), .cmd_register(cmd_register),
    .status_register(status_register), .data_o_register(data_o_register)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int job_h = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic        exp_on = 1'b0;
  logic [31:0] exp_cmd, exp_addr, exp_data, exp_ptr, exp_elapsed;
  logic [1:0]  exp_code;
  logic        exp_busy, exp_jr, exp_wr, exp_rv;

  logic [31:0] wmem [16];
  bit          vpat [16];
  int          vlen;

  logic [31:0] wr_addr_seen [$];
  int          wr_rel_seen [$];
  int          n_read, n_reset, reset_rel, n_rv;
  logic [1:0]  seen_code;
  logic [31:0] seen_elapsed;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Single compare process: model expectations against DUT, plus event capture.
  always @(negedge clk) begin
    if (exp_on) begin
      check_output("cmd_register", cmd_register, exp_cmd);
      check_output("busy", 32'(busy), 32'(exp_busy));
      check_output("job_ready", 32'(job_ready), 32'(exp_jr));
      check_output("word_ready", 32'(word_ready), 32'(exp_wr));
      check_output("res_valid", 32'(res_valid), 32'(exp_rv));
      if (exp_cmd == CMD_WRITE) begin
        check_output("address_register", address_register, exp_addr);
        check_output("data_in_register", data_in_register, exp_data);
      end
      if (exp_cmd == CMD_START)
        check_output("start_cc_pointer_register", start_cc_pointer_register, exp_ptr);
      if (exp_rv) begin
        check_output("res_code", 32'(res_code), 32'(exp_code));
        check_output("res_elapsed", res_elapsed, exp_elapsed);
      end
      if (cmd_register == CMD_WRITE) begin
        wr_addr_seen.push_back(address_register);
        wr_rel_seen.push_back(cyc - job_h);
      end
      if (cmd_register == CMD_READ) n_read++;
      if (cmd_register == CMD_RESET) begin
        n_reset++;
        reset_rel = cyc - job_h;
      end
      if (res_valid) begin
        n_rv++;
        seen_code    = res_code;
        seen_elapsed = res_elapsed;
      end
    end
  end

  // Cycle 0 is the job handshake. The model derives every event cycle from the
  // job timeline: word handshakes, START window, terminal/timeout, report.
  task automatic apply_stimulus(input int base, input int count, input int ptr, input int limit,
                                input int r_off, input int run_len, input logic [31:0] term,
                                input logic [31:0] dval, input int idle_delay, input int hold);
    int w [16];
    int n, j, L, s, f, r, t, i, T, R, q, E, xs, widx;
    bit tmo;
    n = 0;
    j = 0;
    while (n < count) begin
      if ((j >= vlen) || vpat[j]) begin
        w[n] = 1 + j;
        n++;
      end
      j++;
    end
    L   = (count > 0) ? w[count-1] + 1 : 0;
    s   = (count > 0) ? L : 1;
    f   = (count > 0) ? L + 1 : 1;
    r   = s + r_off;
    t   = r + run_len;
    i   = t + idle_delay;
    T   = s + limit;
    tmo = (limit != 0) && (T <= t);
    xs  = (tmo && T < r) ? T : r;
    R   = tmo ? T + 2 : i + 1;
    q   = R + hold;
    E   = q + 1;
    wr_addr_seen.delete();
    wr_rel_seen.delete();
    n_read = 0; n_reset = 0; reset_rel = -1; n_rv = 0;
    seen_code = 2'd0; seen_elapsed = 32'd0;

    for (int k = 0; k <= E; k++) begin
      @(posedge clk); #1;
      if (k == 0) job_h = cyc;
      job_valid            = (k == 0);
      job_base_addr        = AW'(base);
      job_word_count       = AW'(count);
      job_start_cc_pointer = AW'(ptr);
      timeout_limit        = 32'(limit);
      data_o_register      = dval;
      if (tmo && k > T)  status_register = ST_IDLE;
      else if (k < r)    status_register = ST_IDLE;
      else if (k < t)    status_register = ST_RUNNING;
      else if (k < i)    status_register = term;
      else               status_register = ST_IDLE;
      word_valid = 1'b0;
      widx = 0;
      for (int m = 0; m < count; m++) if (w[m] < k) widx++;
      if (count > 0 && k >= 1 && k <= w[count-1])
        word_valid = ((k - 1) >= vlen) || vpat[k-1];
      word_data = word_valid ? wmem[widx] : (32'hBAD0_0000 + 32'(k));
      res_ready = (k >= q);

      exp_busy = (k >= 1) && (k <= q);
      exp_wr   = (count > 0) && (k >= 1) && (k <= w[count-1]);
      exp_rv   = (k >= R) && (k <= q);
      exp_jr   = (k == 0) || ((k > q) && (status_register == ST_IDLE));
      exp_cmd  = CMD_NOP;
      exp_addr = 32'd0;
      exp_data = 32'd0;
      for (int m = 0; m < count; m++) begin
        if (w[m] + 1 == k) begin
          exp_cmd  = CMD_WRITE;
          exp_addr = 32'((base + m) % (1 << AW));
          exp_data = wmem[m];
        end
      end
      if (k >= f && k <= xs) exp_cmd = CMD_START;
      if (tmo) begin
        if (k == T + 1) exp_cmd = CMD_RESET;
      end else begin
        if (k == t + 1) exp_cmd = CMD_READ;
        if (k >= t + 2 && k <= i) exp_cmd = CMD_RESTART;
      end
      exp_ptr     = 32'(ptr);
      exp_code    = tmo ? 2'd3 : (term == ST_ACCEPTED) ? 2'd0 : (term == ST_REJECTED) ? 2'd1 : 2'd2;
      exp_elapsed = tmo ? 32'(limit) : dval;
      exp_on      = 1'b1;
    end
    @(negedge clk); #1;
    exp_on     = 1'b0;
    res_ready  = 1'b0;
    word_valid = 1'b0;
  endtask

  task automatic check_addrs(input string name, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    logic [31:0] lit [3];
    lit[0] = a0; lit[1] = a1; lit[2] = a2;
    check_output({name, "_write_count"}, 32'(wr_addr_seen.size()), 32'd3);
    for (int k = 0; k < 3 && k < wr_addr_seen.size(); k++)
      check_output({name, "_addr"}, wr_addr_seen[k], lit[k]);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; job_valid = 1'b0; job_base_addr = '0; job_word_count = '0;
    job_start_cc_pointer = '0; timeout_limit = '0; word_valid = 1'b1;
    word_data = 32'hFFFF_FFFF; res_ready = 1'b0;
    status_register = ST_RUNNING; data_o_register = 32'hFFFF_FFFF;
    vlen = 0;
    for (int k = 0; k < 16; k++) begin wmem[k] = 32'd0; vpat[k] = 1'b1; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; word_valid = 1'b0;
    @(negedge clk);
    check_output("rst_cmd", cmd_register, CMD_NOP);
    check_output("rst_data_in", data_in_register, 32'd0);
    check_output("rst_address", address_register, 32'd0);
    check_output("rst_ptr", start_cc_pointer_register, 32'd0);
    check_output("rst_elapsed", res_elapsed, 32'd0);
    check_output("rst_code", 32'(res_code), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_job_ready", 32'(job_ready), 32'd0);
    check_output("rst_word_ready", 32'(word_ready), 32'd0);
    check_output("rst_res_valid", 32'(res_valid), 32'd0);
    status_register = ST_IDLE;
    #1 check_output("idle_job_ready", 32'(job_ready), 32'd1);

    $display("[TB] job A: 3-word load at 0x010, accept path");
    wmem[0] = 32'hA1B2_C3D4; wmem[1] = 32'h1122_3344; wmem[2] = 32'h0;
    apply_stimulus(32'h010, 3, 32'h155, 0, 2, 50, ST_ACCEPTED, 32'd50, 4, 5);
    check_addrs("A", 32'h010, 32'h011, 32'h012);
    check_output("A_code", 32'(seen_code), 32'd0);
    check_output("A_elapsed", seen_elapsed, 32'd50);
    check_output("A_res_valid_cycles", 32'(n_rv), 32'd6);
    check_output("A_read_cycles", 32'(n_read), 32'd1);

    $display("[TB] job B: address wrap at 0x7FE, error path, timeout not reached");
    wmem[0] = 32'hDEAD_BEEF; wmem[1] = 32'h0000_0001; wmem[2] = 32'h8000_0000;
    apply_stimulus(32'h7FE, 3, 32'h7FF, 100, 1, 7, ST_ERROR, 32'd7, 2, 0);
    check_addrs("B", 32'h7FE, 32'h7FF, 32'h000);
    check_output("B_code", 32'(seen_code), 32'd2);
    check_output("B_reset_cycles", 32'(n_reset), 32'd0);

    $display("[TB] job C: word_valid pattern 1,0,0,1,1, reject path");
    vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 1; vlen = 5;
    wmem[0] = 32'h0000_00C0; wmem[1] = 32'h0000_00C1; wmem[2] = 32'h0000_00C2;
    apply_stimulus(32'h100, 3, 32'h001, 0, 3, 12, ST_REJECTED, 32'd12, 3, 1);
    check_addrs("C", 32'h100, 32'h101, 32'h102);
    check_output("C_write_rel0", 32'(wr_rel_seen.size() > 0 ? wr_rel_seen[0] : -1), 32'd2);
    check_output("C_write_rel2", 32'(wr_rel_seen.size() > 2 ? wr_rel_seen[2] : -1), 32'd6);
    check_output("C_code", 32'(seen_code), 32'd1);
    vlen = 0;
    for (int k = 0; k < 16; k++) vpat[k] = 1'b1;

    $display("[TB] job D: timeout 20 with status stuck RUNNING");
    apply_stimulus(0, 0, 32'h03C, 20, 1, 1000, ST_ACCEPTED, 32'd999, 2, 2);
    check_output("D_reset_cycles", 32'(n_reset), 32'd1);
    check_output("D_reset_rel", 32'(reset_rel), 32'd22);
    check_output("D_code", 32'(seen_code), 32'd3);
    check_output("D_elapsed", seen_elapsed, 32'd20);

    $display("[TB] job E: timeout disabled, long run");
    apply_stimulus(0, 0, 32'h002, 0, 1, 80, ST_ACCEPTED, 32'd81, 2, 0);
    check_output("E_reset_cycles", 32'(n_reset), 32'd0);
    check_output("E_elapsed", seen_elapsed, 32'd81);

    $display("[TB] job F: timeout and terminal status in the same cycle");
    apply_stimulus(0, 0, 32'h004, 10, 1, 9, ST_ACCEPTED, 32'd55, 2, 0);
    check_output("F_code", 32'(seen_code), 32'd3);
    check_output("F_elapsed", seen_elapsed, 32'd10);

    $display("[TB] reset asserted during RUN");
    @(posedge clk); #1;
    job_valid = 1'b1; job_word_count = '0; job_start_cc_pointer = AW'(5);
    timeout_limit = '0; status_register = ST_IDLE;
    @(posedge clk); #1;
    job_valid = 1'b0; status_register = ST_RUNNING;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_output("mid_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_output("after_rst_cmd", cmd_register, CMD_NOP);
    check_output("after_rst_busy", 32'(busy), 32'd0);
    check_output("after_rst_res_valid", 32'(res_valid), 32'd0);
    check_output("after_rst_ptr", start_cc_pointer_register, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("after_rst_job_ready_busy_wrapper", 32'(job_ready), 32'd0);
    end
    #1 status_register = ST_IDLE;
    #1 check_output("after_rst_job_ready_idle_wrapper", 32'(job_ready), 32'd1);

    $display("[TB] job G: single word after reset");
    wmem[0] = 32'h5A5A_A5A5;
    apply_stimulus(32'h200, 1, 32'h010, 0, 1, 4, ST_ACCEPTED, 32'd4, 2, 1);
    check_output("G_write_count", 32'(wr_addr_seen.size()), 32'd1);
    check_output("G_code", 32'(seen_code), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
